// File: rtl/mfp_ahb_xbar_n.sv
`default_nettype none
// ============================================================================
// Module   : mfp_ahb_xbar_n
// Brief    : Single-master AHB-lite interconnect for N_SLV slaves.
//            - Uses a mask/base address map. The lowest-index match wins.
//            - The data-phase select is registered, and the read response is
//              muxed back to the master.
//            - A built-in default slave answers unmapped transfers with a
//              two-cycle ERROR.
//            - Optional wait-state timeout, enabled with MFP_AHB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mfp_ahb_xbar_n #(
  parameter int                  N_SLV    = 3,
  parameter logic [32*N_SLV-1:0] SLV_BASE = {N_SLV{32'h0}},
  parameter logic [32*N_SLV-1:0] SLV_MASK = {N_SLV{32'h0}},
  parameter int                  TIMEOUT  = 255
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  output logic [31:0]          HRDATA,
  output logic                 HREADY,
  output logic                 HRESP,
  output logic [N_SLV-1:0]     HSEL_S,
  input  logic [32*N_SLV-1:0]  HRDATA_S,
  input  logic [N_SLV-1:0]     HREADYOUT_S,
  input  logic [N_SLV-1:0]     HRESP_S
);

  // ERRx: default-slave error beats. TOx: timeout error beats that override a stuck slave.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ERR1 = 3'd1,
    ST_ERR2 = 3'd2,
    ST_TO1  = 3'd3,
    ST_TO2  = 3'd4
  } state_t;

  logic [N_SLV-1:0] w_hsel;
  logic             w_def_hit;
  logic             w_act;
  logic             w_err_start;
  logic             w_to_hit;
  logic [31:0]      w_s_rdata;
  logic             w_s_ready;
  logic             w_s_resp;
  logic [N_SLV-1:0] r_dsel;
  logic             r_ddef;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_unused;

  // HTRANS[0] (SEQ vs NONSEQ) does not affect routing.
  assign w_unused = HTRANS[0] ^ (TIMEOUT != 0);

  // Address decode: scanning from the top down makes the lowest-index match win.
  always_comb begin
    w_hsel    = '0;
    w_def_hit = 1'b1;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        w_hsel    = '0;
        w_hsel[i] = 1'b1;
        w_def_hit = 1'b0;
      end
    end
  end

  assign HSEL_S      = w_hsel;
  assign w_act       = HTRANS[1] & HREADY;
  assign w_err_start = w_act & w_def_hit;

  // Data-phase select. It advances only when the current beat completes.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dsel <= '0;
      r_ddef <= 1'b0;
    end else if (HREADY) begin
      r_dsel <= w_act ? w_hsel : '0;
      r_ddef <= w_err_start;
    end
  end

  // Slave response mux. An empty data phase is a zero-wait OKAY.
  always_comb begin
    w_s_rdata = '0;
    w_s_ready = 1'b1;
    w_s_resp  = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if (r_dsel[i]) begin
        w_s_rdata = HRDATA_S[32*i +: 32];
        w_s_ready = HREADYOUT_S[i];
        w_s_resp  = HRESP_S[i];
      end
    end
  end

`ifdef MFP_AHB_TIMEOUT_EN
  localparam int               c_CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int               c_CNT_W   = (c_CNT_RAW < 8)  ? 8  :
                                           (c_CNT_RAW > 16) ? 16 : c_CNT_RAW;
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               w_stalling;

  assign w_stalling = (r_state == ST_IDLE) && (r_dsel != '0) && !w_s_ready;
  // The last counted stall cycle arms TO1, so the error starts on stall cycle TIMEOUT+1.
  assign w_to_hit   = w_stalling && (r_wait_cnt == c_TO_LAST);

  // Wait-state counter. Any completed beat restarts it.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wait_cnt <= '0;
    end else if (HREADY) begin
      r_wait_cnt <= '0;
    end else if (w_stalling) begin
      r_wait_cnt <= r_wait_cnt + c_CNT_ONE;
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  // Error FSM state register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Error FSM next state.
  // ERR1 is entered on the same edge that latches an unmapped address phase.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_err_start) begin
          w_state_nxt = ST_ERR1;
        end else if (w_to_hit) begin
          w_state_nxt = ST_TO1;
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      ST_TO1:  w_state_nxt = ST_TO2;
      ST_ERR2,
      ST_TO2:  w_state_nxt = w_err_start ? ST_ERR1 : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Master-facing response. Error beats override whatever the slave drives.
  always_comb begin
    HRDATA = w_s_rdata;
    HREADY = w_s_ready;
    HRESP  = w_s_resp;
    if (r_ddef || (r_state == ST_TO1) || (r_state == ST_TO2)) begin
      HRDATA = '0;
      HRESP  = 1'b1;
      HREADY = (r_state == ST_ERR2) || (r_state == ST_TO2);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mfp_ahb_xbar_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_mfp_ahb_xbar_n
// Brief    : Bench for mfp_ahb_xbar_n. It drives randomised master traffic
//            through behavioural slaves. A queue-based scoreboard plus a
//            monitor checks the responses, and directed cases cover
//            wait-state, reset and stall/timeout behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mfp_ahb_xbar_n;
  localparam int N = 3;
  localparam logic [32*N-1:0] BASE = {32'h1f800000, 32'h00000000, 32'h1fc00000};
  localparam logic [32*N-1:0] MASK = {32'h1fc00000, 32'h10000000, 32'h1fc00000};
  localparam logic [1:0] NONSEQ = 2'b10;

  logic            HCLK, HRESET;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic [31:0]     HRDATA;
  logic            HREADY, HRESP;
  logic [N-1:0]    HSEL_S;
  logic [32*N-1:0] HRDATA_S;
  logic [N-1:0]    HREADYOUT_S, HRESP_S;

  mfp_ahb_xbar_n #(.N_SLV(N), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .HSEL_S(HSEL_S),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct { bit err; logic [31:0] data; int waits; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  bit stuck  = 0;
  int drv_wait = 0;

  logic [31:0] m_base [N] = '{32'h1fc00000, 32'h00000000, 32'h1f800000};
  logic [31:0] m_mask [N] = '{32'h1fc00000, 32'h10000000, 32'h1fc00000};

  // Reference address map: first listed region that matches, or -1.
  function automatic int ref_slave(input logic [31:0] a);
    for (int i = 0; i < N; i++) if ((a & m_mask[i]) == m_base[i]) return i;
    return -1;
  endfunction

  // Read data each behavioural slave returns for an address.
  function automatic logic [31:0] sdata(input int k, input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ (32'h01234567 * (k + 1));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural slaves: one data phase at a time, drv_wait wait states, or forever when stuck.
  initial begin : slaves
    int cur_k, rem;
    logic [31:0] caddr, s_addr;
    logic s_rdy;
    logic [N-1:0] s_sel;
    logic [1:0] s_tr;
    int s_w;
    cur_k = -1; rem = 0; caddr = '0;
    HREADYOUT_S = '1; HRESP_S = '0; HRDATA_S = '0;
    forever begin
      @(negedge HCLK);
      s_rdy = HREADY; s_sel = HSEL_S; s_tr = HTRANS; s_addr = HADDR; s_w = drv_wait;
      @(posedge HCLK); #1;
      if (HRESET) cur_k = -1;
      else begin
        if (cur_k >= 0) begin
          if (s_rdy) cur_k = -1;
          else if (rem > 0) rem--;
        end
        if (s_rdy && s_tr[1]) begin
          cur_k = -1;
          for (int i = 0; i < N; i++) if (s_sel[i]) cur_k = i;
          rem = s_w; caddr = s_addr;
        end
      end
      for (int i = 0; i < N; i++) begin
        HRDATA_S[32*i +: 32] = $urandom;
        HREADYOUT_S[i] = 1'b1;
        HRESP_S[i] = 1'b0;
        if (i == cur_k) begin
          if (stuck || rem > 0) HREADYOUT_S[i] = 1'b0;
          else HRDATA_S[32*i +: 32] = sdata(i, caddr);
        end
      end
    end
  end

  // Issue one address phase and wait for acceptance. When monitoring, push the expected response.
  task automatic put(input logic [31:0] a, input logic [1:0] t, input int w);
    logic acc;
    int n, idx;
    exp_t e;
    HADDR = a; HTRANS = t; drv_wait = w; n = 0; acc = 1'b0;
    do begin
      @(negedge HCLK);
      acc = HREADY;
      if (acc && t[1] && mon_en) begin
        idx = ref_slave(a);
        e.err = (idx < 0);
        e.data = (idx < 0) ? 32'h0 : sdata(idx, a);
        e.waits = (idx < 0) ? 1 : w;
        sb.push_back(e);
      end
      @(posedge HCLK); #1;
      n++;
    end while (!acc && n < 64);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL put_accept: HREADY stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  // Monitor: decode check every cycle, plus the data-phase response against the scoreboard.
  initial begin : monitor
    bit in_dp;
    int wcnt, idx;
    exp_t e;
    in_dp = 0; wcnt = 0;
    forever begin
      @(negedge HCLK);
      if (HRESET || !mon_en) begin in_dp = 0; continue; end
      idx = ref_slave(HADDR);
      chk("hsel_decode", 32'(HSEL_S), (idx < 0) ? 32'h0 : (32'h1 << idx));
      if (in_dp) begin
        if (sb.size() == 0) begin
          checks++; errors++; in_dp = 0;
          $display("FAIL sb_empty: data phase with no expected entry at %0t", $time);
        end else if (HREADY) begin
          e = sb.pop_front();
          chk("resp", 32'(HRESP), 32'(e.err));
          if (!e.err) chk("rdata", HRDATA, e.data);
          chk("wait_states", wcnt, e.waits);
          in_dp = 0;
        end else begin
          wcnt++;
          chk("wait_resp", 32'(HRESP), 32'(sb[0].err));
          if (wcnt > 40) begin
            checks++; errors++; in_dp = 0;
            $display("FAIL stall_bound: %0d waits, required %0d", wcnt, sb[0].waits);
          end
        end
      end else begin
        chk("idle_ready", 32'(HREADY), 32'h1);
        chk("idle_resp", 32'(HRESP), 32'h0);
        chk("idle_rdata", HRDATA, 32'h0);
      end
      if (HREADY && HTRANS[1]) begin in_dp = 1; wcnt = 0; end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] a;
    logic [1:0] t;
    int w, r;
    HRESET = 1'b1; HADDR = '0; HTRANS = '0;
    #12;
    chk("reset_ready", 32'(HREADY), 32'h1);
    chk("reset_resp", 32'(HRESP), 32'h0);
    chk("reset_rdata", HRDATA, 32'h0);
    @(posedge HCLK); #1 HRESET = 1'b0;
    mon_en = 1;

    // Known sequence: slave0, unmapped, back-to-back slave0 -> slave2 -> slave1.
    put(32'h1fc00010, NONSEQ, 0);
    put(32'h1e000000, NONSEQ, 0);
    put(32'h1fc00100, NONSEQ, 0);
    put(32'h1f800040, NONSEQ, 0);
    put(32'h00000080, NONSEQ, 0);

    // Randomised traffic over all regions.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: a = 32'h1fc00000 | ($urandom & 32'h003ffffc);
        1: a = $urandom & 32'hEFFFFFFC;
        2: a = 32'h1f800000 | ($urandom & 32'h003ffffc);
        3: a = 32'h1e000000 | ($urandom & 32'h003ffffc);
        default: a = $urandom;
      endcase
      t = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      w = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      put(a, t, w);
    end
    HTRANS = 2'b00;
    repeat (8) @(posedge HCLK);
    #1 chk("queue_drained", sb.size(), 0);
    mon_en = 0;

    // Three wait states on slave1. The next address waits and its decode follows HADDR.
    put(32'h00000040, NONSEQ, 3);
    HADDR = 32'h1fc00010; HTRANS = NONSEQ; drv_wait = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge HCLK);
      chk("t2_wait_ready", 32'(HREADY), 32'h0);
      chk("t2_hsel_follow", 32'(HSEL_S), 32'h1);
    end
    @(negedge HCLK);
    chk("t2_done_ready", 32'(HREADY), 32'h1);
    chk("t2_rdata", HRDATA, sdata(1, 32'h00000040));
    @(posedge HCLK); #1 HTRANS = 2'b00;
    @(negedge HCLK);
    chk("t2_next_rdata", HRDATA, sdata(0, 32'h1fc00010));

    // Reset during ERR1.
    put(32'h1e000000, NONSEQ, 0);
    HTRANS = 2'b00;
    @(negedge HCLK);
    chk("err1_ready", 32'(HREADY), 32'h0);
    chk("err1_resp", 32'(HRESP), 32'h1);
    #2 HRESET = 1'b1;
    #1;
    chk("rst_err1_ready", 32'(HREADY), 32'h1);
    chk("rst_err1_resp", 32'(HRESP), 32'h0);
    chk("rst_err1_rdata", HRDATA, 32'h0);
    @(posedge HCLK); #1 HRESET = 1'b0;
    put(32'h1fc00020, NONSEQ, 0);
    HTRANS = 2'b00;
    @(negedge HCLK);
    chk("post_rst1_ready", 32'(HREADY), 32'h1);
    chk("post_rst1_rdata", HRDATA, sdata(0, 32'h1fc00020));

    // Reset during a slave stall.
    stuck = 1;
    put(32'h00000040, NONSEQ, 0);
    HTRANS = 2'b00;
    repeat (3) begin
      @(negedge HCLK);
      chk("stall_ready", 32'(HREADY), 32'h0);
    end
    #2 HRESET = 1'b1;
    #1;
    chk("rst_stall_ready", 32'(HREADY), 32'h1);
    chk("rst_stall_resp", 32'(HRESP), 32'h0);
    chk("rst_stall_rdata", HRDATA, 32'h0);
    @(posedge HCLK); #1 HRESET = 1'b0; stuck = 0;
    put(32'h1f800010, NONSEQ, 0);
    HTRANS = 2'b00;
    @(negedge HCLK);
    chk("post_rst2_rdata", HRDATA, sdata(2, 32'h1f800010));
    chk("post_rst2_resp", 32'(HRESP), 32'h0);

    // Slave2 stalls forever.
    stuck = 1;
    put(32'h1f800000, NONSEQ, 0);
    HTRANS = 2'b00;
`ifdef MFP_AHB_TIMEOUT_EN
    begin
      int bad;
      bad = 0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge HCLK);
        if (HREADY !== 1'b0 || HRESP !== 1'b0) bad++;
      end
      chk("to_stall_cycles_bad", bad, 0);
      @(negedge HCLK);
      chk("to1_ready", 32'(HREADY), 32'h0);
      chk("to1_resp", 32'(HRESP), 32'h1);
      @(negedge HCLK);
      chk("to2_ready", 32'(HREADY), 32'h1);
      chk("to2_resp", 32'(HRESP), 32'h1);
      @(negedge HCLK);
      chk("to_after_ready", 32'(HREADY), 32'h1);
      chk("to_after_resp", 32'(HRESP), 32'h0);
      stuck = 0;
    end
`else
    begin
      int lows;
      lows = 0;
      repeat (120) begin
        @(negedge HCLK);
        if (HREADY === 1'b0) lows++;
      end
      chk("stall_forever_low", lows, 120);
      #2 HRESET = 1'b1;
      @(posedge HCLK); #1 HRESET = 1'b0; stuck = 0;
    end
`endif
    put(32'h00000100, NONSEQ, 0);
    HTRANS = 2'b00;
    @(negedge HCLK);
    chk("final_ready", 32'(HREADY), 32'h1);
    chk("final_rdata", HRDATA, sdata(1, 32'h00000100));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
